adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and sum width in bits.
REQ-002 Parameter NUM_REQ, default 4, number of requesters; fixed at 4 for this release; rsp_id width is 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; at most one bit high in any cycle.
REQ-007 req_a  input  NUM_REQ*DATA_WIDTH  operand A; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_b  input  NUM_REQ*DATA_WIDTH  operand B; packing as req_a.
REQ-009 req_cin  input  NUM_REQ  per-requester carry in.
REQ-010 rsp_valid  output  1  result register holds an undelivered result.
REQ-011 rsp_ready  input  1  downstream accepts the result.
REQ-012 rsp_sum  output  DATA_WIDTH  registered sum.
REQ-013 rsp_cout  output  1  registered carry out.
REQ-014 rsp_id  output  2  index of the requester that owns the result.
REQ-015 op_count  output  16  count of delivered results.

Function
REQ-016 The block shall share one DATA_WIDTH-bit adder among NUM_REQ requesters; the result is {cout, sum} = a + b + cin, computed at full DATA_WIDTH+1 width with no truncation of the carry.
REQ-017 The output stage shall be a one-entry register with states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-018 Space shall be defined as (rsp_valid==0) or (rsp_ready==1).
REQ-019 Round-robin arbitration: the highest priority goes to index (last_grant+1) mod NUM_REQ, then increasing index with wrap 3->0; the grant goes to the first requester with req_valid=1 in that order.
REQ-020 req_ready[i] shall be 1 only when requester i is granted and space=1; req_ready is combinational from req_valid, last_grant, rsp_valid and rsp_ready.
REQ-021 An accept occurs when req_valid[i] and req_ready[i] are both 1. On the next edge: rsp_sum and rsp_cout are loaded from requester i's operands, rsp_id is loaded with i, rsp_valid is set to 1, and last_grant is set to i.
REQ-022 Latency shall be 1 cycle from the accept edge to rsp_valid=1. Throughput shall be one operation per cycle while rsp_ready=1.
REQ-023 Delivery occurs when rsp_valid and rsp_ready are both 1. With no simultaneous accept, the state goes FULL->EMPTY. With a simultaneous accept, the state stays FULL and the register holds the new result (back-to-back, no bubble).
REQ-024 While FULL and rsp_ready=0, rsp_sum, rsp_cout and rsp_id shall hold stable, and every req_ready bit shall be 0.
REQ-025 With no req_valid bit set, no grant occurs and last_grant holds.
REQ-026 last_grant shall change only on an accept.
REQ-027 op_count shall increment by 1 on each delivery and saturate at 16'hFFFF; it does not wrap.
REQ-028 A requester holds its req_valid and operands until accepted; the block places no stability requirement on non-granted requesters.
REQ-029 When the sum overflows (e.g. FFFFFFFF+1), rsp_cout=1 and rsp_sum=0.

Reset
REQ-030 While rst_n=0, outputs shall be rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, op_count=0, and last_grant=NUM_REQ-1 (so requester 0 has first priority); req_ready shall be all 0.
REQ-031 An assertion of rst_n mid-operation shall discard any held result immediately (asynchronously), with no delivery counted.
REQ-032 Deassertion of rst_n is synchronised externally; the first accept is possible on the first edge after release.

Verification
REQ-033 Single request: reset, then req_valid=4'b0001, a=5, b=7, cin=1, rsp_ready=1 -> req_ready=4'b0001 that cycle; next cycle rsp_valid=1, rsp_sum=13, rsp_cout=0, rsp_id=0; op_count=1 after delivery.
REQ-034 Overflow: requester 2 sends a=FFFFFFFF, b=00000001, cin=0 -> rsp_sum=00000000, rsp_cout=1, rsp_id=2.
REQ-035 Fairness: all four req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles, and rsp_valid stays high with no bubbles.
REQ-036 Backpressure: result FULL, rsp_ready=0 for 3 cycles with req_valid=4'b1111 -> req_ready=0 throughout and rsp_* stable; the cycle rsp_ready rises, the next requester in rotation is accepted in the same cycle as the delivery.
REQ-037 Reset mid-operation: rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately and op_count=0; after release, requester 0 wins when all four request.
REQ-038 Saturation: preload by driving 65537 deliveries -> op_count=FFFF and it remains FFFF.

Source files
------------

// File: rtl/adder_arbiter.sv
// Shared DATA_WIDTH-bit adder behind a 4-way round-robin arbiter.
// A one-entry output register keeps full throughput while rsp_ready is high.
module adder_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_cin,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_sum,
  output logic                          rsp_cout,
  output logic [1:0]                    rsp_id,
  output logic [15:0]                   op_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                              state, state_nxt;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  a_lane, b_lane;
  logic [1:0]                          last_grant, grant_id, cand;
  logic                                grant_vld, space, accept, deliver;
  logic [DATA_WIDTH:0]                 add_res;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign a_lane[i] = req_a[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_lane[i] = req_b[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan starts one past the last winner; 2-bit wrap gives the 3->0 rotation.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = last_grant;
    cand      = last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_grant + 2'(k);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  // Gated by rst_n so no request is ever acknowledged while held in reset.
  assign space   = rst_n && (!rsp_valid || rsp_ready);
  assign accept  = grant_vld && space;
  assign deliver = rsp_valid && rsp_ready;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  assign add_res = {1'b0, a_lane[grant_id]} + {1'b0, b_lane[grant_id]}
                 + {{DATA_WIDTH{1'b0}}, req_cin[grant_id]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept)              state_nxt = FULL;
      FULL:  if (deliver && !accept)  state_nxt = EMPTY;
      default:                        state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid = (state == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= '0;
      last_grant <= 2'(NUM_REQ-1);
    end else if (accept) begin
      rsp_sum    <= add_res[DATA_WIDTH-1:0];
      rsp_cout   <= add_res[DATA_WIDTH];
      rsp_id     <= grant_id;
      last_grant <= grant_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              op_count <= '0;
    else if (deliver && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized bench for adder_arbiter against a cycle-level behavioural model,
// plus directed scenarios with literal expectations.
module tb_adder_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;

  logic            clk, rst_n;
  logic [NR-1:0]   req_valid, req_ready, req_cin;
  logic [NR*DW-1:0] req_a, req_b;
  logic            rsp_valid, rsp_ready, rsp_cout;
  logic [DW-1:0]   rsp_sum;
  logic [1:0]      rsp_id;
  logic [15:0]     op_count;

  adder_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_id(rsp_id), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: one result slot, the rotation pointer and the delivery count.
  logic          m_full, m_cout;
  logic [DW-1:0] m_sum;
  logic [1:0]    m_id, m_lg;
  logic [15:0]   m_cnt;
  int            exp_g;
  logic [NR-1:0] exp_ready;
  logic [DW:0]   exp_res;

  always_comb begin
    int gi;
    int idx;
    exp_g = -1;
    idx   = 0;
    for (int k = 1; k <= NR; k++) begin
      idx = (int'(m_lg) + k) % NR;
      if (exp_g < 0 && req_valid[idx]) exp_g = idx;
    end
    exp_ready = '0;
    if (rst_n && (!m_full || rsp_ready) && exp_g >= 0) exp_ready = NR'(1) << exp_g;
    gi = (exp_g < 0) ? 0 : exp_g;
    exp_res = {1'b0, req_a[gi*DW +: DW]} + {1'b0, req_b[gi*DW +: DW]}
            + {{DW{1'b0}}, req_cin[gi]};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full <= 1'b0; m_sum <= '0; m_cout <= 1'b0; m_id <= '0;
      m_lg <= 2'(NR-1); m_cnt <= '0;
    end else begin
      if (m_full && rsp_ready && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      if (exp_ready != '0) begin
        m_full <= 1'b1;
        m_sum  <= exp_res[DW-1:0];
        m_cout <= exp_res[DW];
        m_id   <= 2'(exp_g);
        m_lg   <= 2'(exp_g);
      end else if (m_full && rsp_ready) begin
        m_full <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("op_count",  64'(op_count),  64'(m_cnt));
    if (m_full) begin
      chk("rsp_sum",  64'(rsp_sum),  64'(m_sum));
      chk("rsp_cout", 64'(rsp_cout), 64'(m_cout));
      chk("rsp_id",   64'(rsp_id),   64'(m_id));
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic rand_ops;
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = ($urandom_range(0, 7) == 0) ? {DW{1'b1}} : DW'($urandom);
      req_b[i*DW +: DW] = ($urandom_range(0, 7) == 0) ? {DW{1'b1}} : DW'($urandom);
    end
    req_cin = NR'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0; req_valid = 4'hF;
    rand_ops();
    repeat (3) tick();
    #2;
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset op_count",  64'(op_count),  64'd0);
    chk("reset rsp_id",    64'(rsp_id),    64'd0);
    chk("reset rsp_sum",   64'(rsp_sum),   64'd0);

    // single request
    rst_n = 1'b1;
    req_valid = 4'b0001; req_a[0 +: DW] = 5; req_b[0 +: DW] = 7; req_cin = 4'b0001;
    rsp_ready = 1'b1;
    #1 chk("single req_ready", 64'(req_ready), 64'b0001);
    tick(); req_valid = '0;
    #2;
    chk("single rsp_valid", 64'(rsp_valid), 64'd1);
    chk("single rsp_sum",   64'(rsp_sum),   64'd13);
    chk("single rsp_cout",  64'(rsp_cout),  64'd0);
    chk("single rsp_id",    64'(rsp_id),    64'd0);
    tick(); #2;
    chk("single op_count",  64'(op_count),  64'd1);
    chk("single drained",   64'(rsp_valid), 64'd0);

    // overflow on requester 2
    req_valid = 4'b0100; req_a[2*DW +: DW] = 32'hFFFF_FFFF; req_b[2*DW +: DW] = 32'h1;
    req_cin = 4'b0000;
    tick(); req_valid = '0;
    #2;
    chk("ovf rsp_sum",  64'(rsp_sum),  64'd0);
    chk("ovf rsp_cout", 64'(rsp_cout), 64'd1);
    chk("ovf rsp_id",   64'(rsp_id),   64'd2);
    tick();

    // reset while a result is held
    req_valid = 4'b0001;
    tick(); req_valid = '0; rsp_ready = 1'b0;
    #2 chk("pre-reset rsp_valid", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async reset op_count",  64'(op_count),  64'd0);
    tick();
    rst_n = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
    rand_ops();
    #1 chk("post-reset winner", 64'(req_ready), 64'b0001);

    // fairness: 0,1,2,3,0 back to back
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      chk("fair rsp_id",    64'(rsp_id),    64'(k % 4));
      chk("fair rsp_valid", 64'(rsp_valid), 64'd1);
    end

    // backpressure with all requesting
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp req_ready", 64'(req_ready), 64'd0);
      chk("bp rsp_id",    64'(rsp_id),    64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("bp release req_ready", 64'(req_ready), 64'b0010);
    tick(); #1;
    chk("bp release rsp_id",   64'(rsp_id),   64'd1);
    chk("bp release op_count", 64'(op_count), 64'd5);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      req_valid = NR'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      tick();
    end

    // saturation
    rst_n = 1'b0; #1 rst_n = 1'b1;
    req_valid = 4'b0001; rsp_ready = 1'b1;
    repeat (65540) tick();
    #1 chk("sat op_count", 64'(op_count), 64'hFFFF);
    repeat (3) tick();
    #1;
    chk("sat hold op_count", 64'(op_count), 64'hFFFF);
    chk("sat rsp_valid",     64'(rsp_valid), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
